// File: rtl/mips_imem_pkg.sv
// Shared types and constants for the instruction-memory fetch controller.
package mips_imem_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD0   = 3'd1,
    S_RD1   = 3'd2,
    S_RD2   = 3'd3,
    S_RD3   = 3'd4,
    S_LAST  = 3'd5,
    S_DONE  = 3'd6,
    S_WRITE = 3'd7
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned LO_BYTES_W     = 8 * (BYTES_PER_WORD - 1);
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  localparam int unsigned NUM_REQ   = 2;
  localparam int unsigned GNT_FETCH = 0;
  localparam int unsigned GNT_LOAD  = 1;

  // A fetch is rejected when it is not word aligned or lies beyond the memory.
  function automatic logic fetch_bad(input logic [31:0] pc, input int unsigned mem_bytes);
    return (pc[1:0] != 2'b00) || (pc >= 32'(mem_bytes));
  endfunction

endpackage

// File: rtl/mips_imem_rr_arb.sv
// Two-way round-robin arbiter between the fetch and loader requesters.
module mips_imem_rr_arb
  import mips_imem_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  // Lone requester wins; on a conflict the one not served last wins.
  always_comb begin
    grant = '0;
    if (enable) begin
      if (req[GNT_FETCH] && req[GNT_LOAD]) begin
        if (last_grant == 1'(GNT_LOAD)) grant[GNT_FETCH] = 1'b1;
        else                            grant[GNT_LOAD]  = 1'b1;
      end else begin
        grant = req;
      end
    end
  end

endmodule

// File: rtl/mips_imem_fetch_ctrl.sv
// Shares a byte-wide synchronous instruction RAM between CPU fetch and boot loader.
module mips_imem_fetch_ctrl
  import mips_imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128,
  parameter int unsigned ADDR_W    = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ack,
  output logic              instr_valid,
  output logic [31:0]       instruction,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_ack,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e                  state;
  logic                    last_grant;
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ-1:0]      grant;
  logic                    arb_en;
  logic [ADDR_W-1:0]       addr_q;
  logic [7:0]              wdata_q;
  logic                    en_q;
  logic                    we_q;
  logic [LO_BYTES_W-1:0]   lo_bytes;

  // Request vector in grant-ID order.
  always_comb begin
    req            = '0;
    req[GNT_FETCH] = fetch_req;
    req[GNT_LOAD]  = load_req;
  end

  assign arb_en = (state == S_IDLE) && rst_n;

  mips_imem_rr_arb u_arb (
    .req        (req),
    .enable     (arb_en),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign fetch_ack = grant[GNT_FETCH];
  assign load_ack  = grant[GNT_LOAD];
  assign busy      = (state != S_IDLE);

  // Reset kills any access in flight during the reset cycle itself.
  assign mem_en    = en_q & rst_n;
  assign mem_we    = we_q & mem_en;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;

  // Sequencer: arbitration in IDLE, four byte reads for a fetch, one write for a load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      last_grant  <= 1'(GNT_FETCH);
      addr_q      <= '0;
      wdata_q     <= '0;
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      lo_bytes    <= '0;
      instr_valid <= 1'b0;
      fetch_err   <= 1'b0;
      instruction <= NOP_INSTR;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant[GNT_LOAD]) begin
            last_grant <= 1'(GNT_LOAD);
            addr_q     <= load_addr;
            wdata_q    <= load_data;
            en_q       <= 1'b1;
            we_q       <= 1'b1;
            state      <= S_WRITE;
          end else if (grant[GNT_FETCH]) begin
            last_grant <= 1'(GNT_FETCH);
            if (fetch_bad(fetch_pc, MEM_BYTES)) begin
              instr_valid <= 1'b1;
              fetch_err   <= 1'b1;
              instruction <= NOP_INSTR;
              state       <= S_DONE;
            end else begin
              addr_q <= fetch_pc[ADDR_W-1:0];
              en_q   <= 1'b1;
              state  <= S_RD0;
            end
          end
        end
        S_RD0: begin
          addr_q <= addr_q + ADDR_W'(1);
          state  <= S_RD1;
        end
        S_RD1: begin
          lo_bytes[7:0] <= mem_rdata;
          addr_q        <= addr_q + ADDR_W'(1);
          state         <= S_RD2;
        end
        S_RD2: begin
          lo_bytes[15:8] <= mem_rdata;
          addr_q         <= addr_q + ADDR_W'(1);
          state          <= S_RD3;
        end
        S_RD3: begin
          lo_bytes[23:16] <= mem_rdata;
          addr_q          <= '0;
          en_q            <= 1'b0;
          state           <= S_LAST;
        end
        S_LAST: begin
          instruction <= {mem_rdata, lo_bytes};
          instr_valid <= 1'b1;
          fetch_err   <= 1'b0;
          state       <= S_DONE;
        end
        S_DONE: begin
          instr_valid <= 1'b0;
          state       <= S_IDLE;
        end
        S_WRITE: begin
          addr_q  <= '0;
          wdata_q <= '0;
          en_q    <= 1'b0;
          we_q    <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_imem_fetch_ctrl.sv
// Directed plus randomized bench for the instruction-memory fetch controller.
module tb_mips_imem_fetch_ctrl;

  localparam int unsigned AW = 7;
  localparam int unsigned MB = 128;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fetch_req;
  logic [31:0]   fetch_pc;
  logic          fetch_ack;
  logic          instr_valid;
  logic [31:0]   instruction;
  logic          fetch_err;
  logic          load_req;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          load_ack;
  logic          busy;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  always #5 clk = ~clk;

  mips_imem_fetch_ctrl #(.MEM_BYTES(MB), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ack(fetch_ack),
    .instr_valid(instr_valid), .instruction(instruction), .fetch_err(fetch_err),
    .load_req(load_req), .load_addr(load_addr), .load_data(load_data), .load_ack(load_ack),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Byte RAM with one-cycle read latency, plus a write counter.
  logic [7:0] mem     [MB];
  logic [7:0] pre     [MB];
  logic [7:0] ref_mem [MB];
  logic       preload = 1'b0;
  int         wr_count = 0;
  int         cyc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < MB; i++) mem[i] <= pre[i];
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr] <= mem_wdata;
        wr_count      <= wr_count + 1;
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: little-endian word from the model image, addresses modulo memory size.
  function automatic logic [31:0] model_word(input logic [31:0] pc);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < 4; k++)
      w = w | (32'(ref_mem[int'((pc + 32'(k)) % MB)]) << (8 * k));
    return w;
  endfunction

  function automatic logic model_err(input logic [31:0] pc);
    return ((pc % 4) != 0) || (pc >= MB);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [7:0] d);
    bit got;
    int w0;
    got = 1'b0;
    tick();
    load_req = 1'b1; load_addr = a; load_data = d;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = load_ack;
    end
    chk($sformatf("load_ack@%0d", a), 32'(got), 32'd1);
    w0 = wr_count;
    tick();
    load_req = 1'b0; load_addr = '0; load_data = '0;
    @(negedge clk);
    if (got) begin
      chk("wr_en",   32'(mem_en),    32'd1);
      chk("wr_we",   32'(mem_we),    32'd1);
      chk("wr_addr", 32'(mem_addr),  32'(a));
      chk("wr_data", 32'(mem_wdata), 32'(d));
      ref_mem[a] = d;
    end
    tick();
    chk("wr_once", 32'(wr_count - w0), 32'(got));
  endtask

  task automatic do_fetch(input logic [31:0] pc);
    bit got;
    logic [31:0] exp_w;
    logic exp_e;
    got   = 1'b0;
    exp_e = model_err(pc);
    exp_w = exp_e ? 32'h0 : model_word(pc);
    tick();
    fetch_req = 1'b1; fetch_pc = pc;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      got = fetch_ack;
    end
    chk($sformatf("fetch_ack@%0h", pc), 32'(got), 32'd1);
    tick();
    fetch_req = 1'b0; fetch_pc = '0;
    if (got) begin
      if (exp_e) begin
        @(negedge clk);
        chk("err_valid", 32'(instr_valid), 32'd1);
        chk("err_flag",  32'(fetch_err),   32'd1);
        chk("err_word",  instruction,      32'h0);
        chk("err_no_mem", 32'(mem_en),     32'd0);
      end else begin
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("rd_en",   32'(mem_en), 32'd1);
          chk("rd_we",   32'(mem_we), 32'd0);
          chk("rd_addr", 32'(mem_addr), (pc + 32'(k)) % MB);
        end
        @(negedge clk);
        chk("last_en",     32'(mem_en),      32'd0);
        chk("early_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        chk("fetch_valid", 32'(instr_valid), 32'd1);
        chk("fetch_err0",  32'(fetch_err),   32'd0);
        chk($sformatf("fetch_word@%0h", pc), instruction, exp_w);
      end
    end
  endtask

  int          n, nv, last_c, w0, ack_c0, ack_c1, hold_bad, mism;
  bit          seen, got1;
  logic [31:0] exp_w, w0w, w1w;
  int          order[$];
  logic [AW-1:0] ra;
  logic [7:0]  rd;
  logic [31:0] rpc;

  initial begin
    rst_n = 1'b0; fetch_req = 1'b0; fetch_pc = '0;
    load_req = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < MB; i++) begin
      pre[i]     = 8'($urandom);
      ref_mem[i] = pre[i];
    end
    pre[0] = 8'h13; pre[1] = 8'h00; pre[2] = 8'h08; pre[3] = 8'h20;
    for (int i = 0; i < 4; i++) ref_mem[i] = pre[i];
    preload = 1'b1;
    tick();
    preload = 1'b0;

    // Reset state, with a fetch request that must not be acknowledged.
    fetch_req = 1'b1;
    @(negedge clk);
    chk("rst_busy",  32'(busy),        32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instruction,      32'h0);
    chk("rst_ack",   32'(fetch_ack),   32'd0);
    chk("rst_en",    32'(mem_en),      32'd0);
    tick();
    fetch_req = 1'b0;
    rst_n = 1'b1;

    // Single fetch of the preloaded word.
    do_fetch(32'h0);

    // Loader burst to the top of memory, request held high throughout.
    tick();
    w0 = wr_count; n = 0; last_c = 0;
    load_req = 1'b1; load_addr = AW'(124); load_data = 8'hAA;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (load_ack) begin
        if (n > 0) chk("load_spacing", 32'(cyc - last_c), 32'd2);
        last_c = cyc;
        ref_mem[load_addr] = load_data;
        n++;
        tick();
        if (n < 4) begin
          load_addr = load_addr + AW'(1);
          load_data = load_data + 8'h11;
        end else begin
          load_req = 1'b0;
        end
      end
    end
    tick();
    chk("burst_acks",   32'(n), 32'd4);
    chk("burst_writes", 32'(wr_count - w0), 32'd4);
    do_fetch(32'd124);

    // Misaligned and out-of-range fetches.
    do_fetch(32'h6);
    do_fetch(32'h80);

    // Contention from reset: grants alternate starting with the loader.
    tick();
    rst_n = 1'b0;
    fetch_req = 1'b1; fetch_pc = 32'd8;
    load_req = 1'b1; load_addr = AW'($urandom); load_data = 8'($urandom);
    tick();
    rst_n = 1'b1;
    w0 = wr_count; n = 0; nv = 0; exp_w = 32'h0;
    order.delete();
    for (int i = 0; i < 120 && (n < 4 || nv < 2); i++) begin
      @(negedge clk);
      if (instr_valid) begin
        chk("cont_word", instruction, exp_w);
        nv++;
      end
      if (load_ack || fetch_ack) begin
        order.push_back(load_ack ? 1 : 0);
        if (load_ack) ref_mem[load_addr] = load_data;
        else          exp_w = model_word(32'd8);
        n++;
        tick();
        if (n >= 4) begin
          load_req = 1'b0; fetch_req = 1'b0;
        end else if (order[$] == 1) begin
          load_addr = AW'($urandom); load_data = 8'($urandom);
        end
      end
    end
    chk("cont_grants", 32'(n),  32'd4);
    chk("cont_valids", 32'(nv), 32'd2);
    for (int i = 0; i < order.size(); i++)
      chk($sformatf("grant_order%0d", i), 32'(order[i]), (i % 2 == 0) ? 32'd1 : 32'd0);
    chk("cont_writes", 32'(wr_count - w0), 32'd2);

    // Reset while the fetch is in RD2: no completion follows.
    tick();
    fetch_req = 1'b1; fetch_pc = 32'h0; got1 = 1'b0;
    for (int i = 0; i < 64 && !got1; i++) begin
      @(negedge clk);
      got1 = fetch_ack;
    end
    chk("rstrd_ack", 32'(got1), 32'd1);
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstrd_en", 32'(mem_en), 32'd0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstrd_busy",  32'(busy),   32'd0);
    chk("rstrd_instr", instruction, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (instr_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("rstrd_no_valid", 32'(seen), 32'd0);

    // Reset during the WRITE cycle: the byte must not change.
    ra = AW'($urandom_range(16, 120));
    rd = ~ref_mem[ra];
    tick();
    load_req = 1'b1; load_addr = ra; load_data = rd; got1 = 1'b0;
    for (int i = 0; i < 64 && !got1; i++) begin
      @(negedge clk);
      got1 = load_ack;
    end
    chk("rstwr_ack", 32'(got1), 32'd1);
    w0 = wr_count;
    tick();
    load_req = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstwr_we", 32'(mem_we), 32'd0);
    chk("rstwr_en", 32'(mem_en), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rstwr_count", 32'(wr_count - w0), 32'd0);
    chk("rstwr_byte",  32'(mem[ra]), 32'(ref_mem[ra]));

    // Back-to-back fetches with the request held continuously.
    tick();
    n = 0; nv = 0; hold_bad = 0; ack_c0 = 0; ack_c1 = 0;
    w0w = model_word(32'h0);
    w1w = model_word(32'h4);
    fetch_req = 1'b1; fetch_pc = 32'h0;
    for (int i = 0; i < 60 && nv < 2; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        chk("b2b_word", instruction, (nv == 0) ? w0w : w1w);
        nv++;
      end else if (nv == 1 && instruction !== w0w) begin
        hold_bad++;
      end
      if (fetch_ack) begin
        if (n == 0) ack_c0 = cyc;
        else        ack_c1 = cyc;
        n++;
        tick();
        if (n == 1) fetch_pc = 32'h4;
        else begin
          fetch_req = 1'b0; fetch_pc = '0;
        end
      end
    end
    chk("b2b_acks",    32'(n),  32'd2);
    chk("b2b_valids",  32'(nv), 32'd2);
    chk("b2b_spacing", 32'(ack_c1 - ack_c0), 32'd7);
    chk("b2b_hold",    32'(hold_bad), 32'd0);

    // Randomized mix of loads and fetches against the model image.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        do_load(AW'($urandom), 8'($urandom));
      end else begin
        if ($urandom_range(0, 3) == 0) rpc = 32'($urandom_range(0, 255));
        else                           rpc = 32'(4 * $urandom_range(0, 31));
        do_fetch(rpc);
      end
    end

    // Final memory image must match every accepted write.
    mism = 0;
    for (int i = 0; i < MB; i++)
      if (mem[i] !== ref_mem[i]) mism++;
    chk("mem_image", 32'(mism), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_imem_fetch_ctrl.md
Name: mips_imem_fetch_ctrl

Overview:
- Sequences and shares a byte-wide, synchronous-read instruction memory (128 x 8, little-endian words) between two requesters.
- The CPU fetch port reads a 32-bit instruction as four byte reads; the boot-loader port writes single bytes.
- Sits between the fetch stage and the instruction byte RAM, replacing direct combinational ROM indexing by PC.

Parameters:
- MEM_BYTES, 128, instruction memory size in bytes; must equal 2**ADDR_W.
- ADDR_W, 7, byte address width of the memory port.

Ports:
- CLK  in  1  single clock, all state updates on the rising edge.
- RST_N  in  1  synchronous, active-low reset.
- FETCH_REQ  in  1  fetch request; held high with stable FETCH_PC until FETCH_ACK.
- FETCH_PC  in  32  byte address of the instruction.
- FETCH_ACK  out  1  one-cycle pulse; FETCH_PC has been latched.
- INSTR_VALID  out  1  one-cycle pulse; INSTRUCTION and FETCH_ERR are valid.
- INSTRUCTION  out  32  assembled word {b3,b2,b1,b0}; held until the next completion.
- FETCH_ERR  out  1  fetch was misaligned or out of range; valid with INSTR_VALID.
- LOAD_REQ  in  1  byte-write request; held high with stable address/data until LOAD_ACK.
- LOAD_ADDR  in  ADDR_W  byte address to write.
- LOAD_DATA  in  8  byte to write.
- LOAD_ACK  out  1  one-cycle pulse; write accepted.
- BUSY  out  1  high in any state other than IDLE.
- MEM_EN  out  1  memory access strobe.
- MEM_WE  out  1  write enable, qualified by MEM_EN.
- MEM_ADDR  out  ADDR_W  memory byte address.
- MEM_WDATA  out  8  write data.
- MEM_RDATA  in  8  read data, returned one cycle after an MEM_EN=1, MEM_WE=0 cycle.

Behaviour:
- States: IDLE, RD0, RD1, RD2, RD3, LAST, DONE, WRITE.
- Reset (RST_N=0 at an edge): go to IDLE. All outputs reset to 0, including INSTRUCTION=32'h0 and the round-robin pointer (pointer=FETCH).
- While RST_N=0, MEM_EN and MEM_WE are forced to 0 combinationally, so no access completes in the reset cycle.
- Reset mid-fetch: no INSTR_VALID is produced. Reset in a WRITE cycle: the write is suppressed.
- Arbitration happens only in IDLE. ACK outputs are combinational in IDLE.
  - One requester active: that requester is granted.
  - Both active: round-robin; grant the requester not granted last. The first conflict after reset goes to LOAD.
- Fetch, accepted in cycle T:
  - FETCH_PC is latched as base.
  - T+1..T+4: states RD0..RD3 drive MEM_EN=1, MEM_WE=0, MEM_ADDR=base+k for k=0..3.
  - Byte k is captured at the end of cycle T+2+k, in states RD1, RD2, RD3, LAST.
  - T+6: DONE, INSTR_VALID=1, FETCH_ERR=0. IDLE at T+7.
  - Accept-to-valid latency is 6 cycles; minimum spacing between fetch acks is 7 cycles.
- Fetch error: FETCH_PC[1:0]!=0 or FETCH_PC[31:ADDR_W]!=0.
  - Accepted normally in cycle T, with no memory access.
  - T+1: DONE with INSTR_VALID=1, FETCH_ERR=1, INSTRUCTION=32'h0000_0000 (MIPS NOP).
- Load, accepted in cycle T:
  - Address and data are latched.
  - T+1: WRITE drives MEM_EN=1, MEM_WE=1, latched MEM_ADDR and MEM_WDATA.
  - T+2: IDLE. Throughput is 1 byte per 2 cycles.
- Address arithmetic is modulo 2**ADDR_W. In-range aligned fetches never wrap; the highest valid fetch is MEM_BYTES-4.
- A request dropped before its ack has no effect. Requests arriving while BUSY wait.
- When MEM_EN=0: MEM_ADDR and MEM_WDATA are 0 and MEM_WE=0.

Decomposition:
- Shared package/header mips_imem_pkg holds:
  - state encodings;
  - BYTES_PER_WORD=4;
  - NOP_INSTR=32'h0000_0000;
  - grant IDs GNT_FETCH=0, GNT_LOAD=1.
- Sub-module mips_imem_rr_arb: 2-way round-robin arbiter with inputs req[1:0], enable (IDLE) and pointer state, output grant one-hot.

Test Plan:
- Reset then single fetch: preload memory bytes 0..3 = 8'h13,8'h00,8'h08,8'h20; FETCH_PC=0 acked at T -> MEM_ADDR 0,1,2,3 on T+1..T+4; INSTR_VALID at T+6 with INSTRUCTION=32'h2008_0013, FETCH_ERR=0.
- Loader then fetch: LOAD bytes 8'hAA,8'hBB,8'hCC,8'hDD to addresses 124..127 (4 acks, 2 cycles apart) -> fetch PC=124 returns 32'hDDCC_BBAA.
- Errors: FETCH_PC=32'h6 -> INSTR_VALID one cycle after ack, FETCH_ERR=1, INSTRUCTION=0, no MEM_EN. FETCH_PC=32'h80 -> same.
- Contention: FETCH_REQ and LOAD_REQ both held high from reset -> grant order LOAD, FETCH, LOAD, FETCH; each write seen on the memory port exactly once.
- Reset mid-op: RST_N low during RD2 -> no INSTR_VALID, BUSY=0 next cycle. RST_N low during WRITE -> MEM_WE=0 that cycle and target byte unchanged.
- Back-to-back fetches PC=0 then PC=4 held continuously -> second FETCH_ACK exactly 7 cycles after the first; INSTRUCTION holds the first word until the second INSTR_VALID.
